cdc_lock_fifo: RTL

CDC_LOCK_FIFO -- requirements
Module: cdc_lock_fifo

---
 rtl/cdc_lock_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cdc_lock_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdc_lock_fifo
// Brief    : Locks onto the 3:2 strobe cadence from the 3g->2g sampler and
//            buffers words that arrive with correct spacing in a small FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_lock_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 4,
    parameter int LOCK_CNT = 4
) (
    input  logic                     clk_2g,
    input  logic                     rst_n,
    input  logic                     strobe_in,
    input  logic [DW-1:0]            data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     locked,
    output logic                     lock_err,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     overflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_good_w = $clog2(LOCK_CNT + 1);
    localparam logic [c_good_w-1:0] c_good_last = c_good_w'(LOCK_CNT - 1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_gap;
    logic [c_good_w-1:0]   r_good;
    logic                  r_locked;
    logic                  r_lock_err;
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_overflow;
    logic [DW-1:0]         r_mem [DEPTH];

    logic w_gap_ok;
    logic w_early;
    logic w_missing;
    logic w_wr_req;
    logic w_pop;
    logic w_full;
    logic w_push;

    // r_gap holds the cycles elapsed since the previous strobe, so a strobe
    // seen with r_gap==2 is exactly one strobe per two clk_2g cycles.
    assign w_gap_ok  = strobe_in  && (r_gap == 2'd2);
    assign w_early   = strobe_in  && (r_gap == 2'd1);
    assign w_missing = !strobe_in && (r_gap == 2'd2);

    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= 2'd3;
        end else if (strobe_in) begin
            r_gap <= 2'd1;
        end else if (r_gap != 2'd3) begin
            r_gap <= r_gap + 2'd1;
        end
    end

    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= UNLOCK;
            r_good     <= '0;
            r_locked   <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_lock_err <= 1'b0;
            case (r_state)
                UNLOCK: begin
                    if (strobe_in) begin
                        r_state <= ACQ;
                        r_good  <= '0;
                    end
                end
                ACQ: begin
                    if (w_early || w_missing) begin
                        r_state <= UNLOCK;
                    end else if (w_gap_ok) begin
                        r_good <= r_good + c_good_w'(1);
                        if (r_good == c_good_last) begin
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (w_early || w_missing) begin
                        r_state    <= UNLOCK;
                        r_locked   <= 1'b0;
                        r_lock_err <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= UNLOCK;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign w_wr_req = (r_state == LOCK) && w_gap_ok;
    assign w_pop    = out_valid && out_ready;
    assign w_full   = (r_cnt == c_depth);
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign w_push   = w_wr_req && (!w_full || w_pop);

    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
                2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_wr_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2g) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign out_valid = (r_cnt != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign locked    = r_locked;
    assign lock_err  = r_lock_err;
    assign fifo_cnt  = r_cnt;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
